lif_layer: RTL and testbench

Parametrised, time-multiplexed fully-connected layer of leaky integrate-and-fire neurons with adaptive thresholds and a run-time writable weight matrix. It replaces the fixed, hand-instantiated input, hidden and output neuron groups of the spiking network top. Layers chain by connecting one layer's `spike_o`/`spike_valid_o` to the next layer's `spike_i`/`step_valid_i`. One shared accumulate/update datapath serves all neurons, trading latency for area.

---
 rtl/snn_pkg.sv | 39 +++
 rtl/lif_update.sv | 40 ++++
 rtl/lif_layer.sv | 179 +++++++++++++++++
 tb/tb_lif_layer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types, default neuron constants and saturating helpers for the
// spiking-network layers.
package snn_pkg;

  // Per-layer step sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DONE   = 2'd3
  } lif_state_t;

  // Default neuron dynamics, shared by every layer instance.
  localparam int DEF_THRESHOLD     = 32;
  localparam int DEF_THRESHOLD_INC = 4;
  localparam int DEF_THRESHOLD_DEC = 2;
  localparam int DEF_THRESHOLD_MIN = 16;
  localparam int DEF_LEAK_SHIFT    = 1;

  // Unsigned a + b, clamped to max_v. Callers cast down to their own width.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_v);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, max_v}) return max_v;
    return s[31:0];
  endfunction

  // Unsigned max(a - b, floor_v); an underflowing difference also yields floor_v.
  function automatic logic [31:0] sat_sub(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] floor_v);
    if (a < b) return floor_v;
    if ((a - b) < floor_v) return floor_v;
    return a - b;
  endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational leak / integrate / fire / threshold-adapt step for one
// neuron. Purely combinational so a parallel layer can replicate it.
module lif_update
  import snn_pkg::*;
#(
  parameter int VW            = 12,
  parameter int ACC_W         = 11,
  parameter int THRESHOLD_INC = DEF_THRESHOLD_INC,
  parameter int THRESHOLD_DEC = DEF_THRESHOLD_DEC,
  parameter int THRESHOLD_MIN = DEF_THRESHOLD_MIN,
  parameter int LEAK_SHIFT    = DEF_LEAK_SHIFT
) (
  input  logic [VW-1:0]    v_i,
  input  logic [VW-1:0]    thr_i,
  input  logic [ACC_W-1:0] acc_i,
  output logic [VW-1:0]    v_next_o,
  output logic [VW-1:0]    thr_next_o,
  output logic             fire_o
);

  localparam logic [31:0] VMAX = 32'((64'd1 << VW) - 64'd1);

  logic [VW-1:0] w_leaked;
  logic [VW-1:0] w_vn;

  // Leak, integrate with saturation, then compare against the pre-update threshold.
  always_comb begin
    w_leaked = v_i - (v_i >> LEAK_SHIFT);
    w_vn     = VW'(sat_add(32'(w_leaked), 32'(acc_i), VMAX));
    fire_o   = (w_vn >= thr_i);
    if (fire_o) begin
      v_next_o   = '0;
      thr_next_o = VW'(sat_add(32'(thr_i), 32'(THRESHOLD_INC), VMAX));
    end else begin
      v_next_o   = w_vn;
      thr_next_o = VW'(sat_sub(32'(thr_i), 32'(THRESHOLD_DEC), 32'(THRESHOLD_MIN)));
    end
  end

endmodule

// File: rtl/lif_layer.sv
// Time-multiplexed fully-connected layer of leaky integrate-and-fire neurons.
// One accumulate/update datapath walks every (neuron, input) pair per step.
//
// Handshake: a timestep is accepted on a rising clk edge where step_valid_i
// and step_ready_o are both high; step_valid_i while not ready is ignored.
// spike_valid_o is a one-cycle pulse marking a new spike_o; step_ready_o
// stays low through that pulse and rises the cycle after it.
module lif_layer
  import snn_pkg::*;
#(
  parameter int N_IN          = 8,
  parameter int N_OUT         = 10,
  parameter int WIDTH_P       = 8,
  parameter int THRESHOLD     = DEF_THRESHOLD,
  parameter int THRESHOLD_INC = DEF_THRESHOLD_INC,
  parameter int THRESHOLD_DEC = DEF_THRESHOLD_DEC,
  parameter int THRESHOLD_MIN = DEF_THRESHOLD_MIN,
  parameter int LEAK_SHIFT    = DEF_LEAK_SHIFT,
  localparam int VW = WIDTH_P + $clog2(N_IN) + 1,
  localparam int AW = $clog2(N_IN * N_OUT)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic [N_IN-1:0]    spike_i,
  input  logic               step_valid_i,
  output logic               step_ready_o,
  output logic [N_OUT-1:0]   spike_o,
  output logic               spike_valid_o,
  input  logic               w_we_i,
  input  logic [AW-1:0]      w_addr_i,
  input  logic [WIDTH_P-1:0] w_data_i,
  output logic [1:0]         dbg_state_o
);

  localparam int ACC_W = WIDTH_P + $clog2(N_IN);
  localparam int NW    = N_IN * N_OUT;
  localparam int IW    = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int JW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
  localparam logic [JW-1:0] J_LAST = JW'(N_OUT - 1);
  localparam logic [AW:0]   NW_L   = (AW + 1)'(NW);
  localparam logic [AW-1:0] N_IN_A = AW'(N_IN);

  lif_state_t         r_state;
  lif_state_t         w_state_next;
  logic [IW-1:0]      r_i;
  logic [JW-1:0]      r_j;
  logic [ACC_W-1:0]   r_acc;
  logic [N_IN-1:0]    r_spike_q;
  logic [N_OUT-1:0]   r_spike_q_out;
  logic [N_OUT-1:0]   r_spike_o;
  logic               r_spike_valid;
  logic [WIDTH_P-1:0] r_w   [NW];
  logic [VW-1:0]      r_v   [N_OUT];
  logic [VW-1:0]      r_thr [N_OUT];

  logic               w_accept;
  logic [AW-1:0]      w_rd_addr;
  logic [ACC_W-1:0]   w_addend;
  logic [VW-1:0]      w_v_next;
  logic [VW-1:0]      w_thr_next;
  logic               w_fire;

  // The pulse cycle is excluded so ready rises only after spike_valid_o falls.
  assign step_ready_o  = (r_state == ST_IDLE) && !r_spike_valid;
  assign w_accept      = step_ready_o && step_valid_i;
  assign spike_o       = r_spike_o;
  assign spike_valid_o = r_spike_valid;
  assign dbg_state_o   = r_state;

  // Combinational RAM read: a same-cycle write to this address is seen next cycle.
  assign w_rd_addr = AW'(r_j) * N_IN_A + AW'(r_i);
  assign w_addend  = r_spike_q[r_i] ? ACC_W'(r_w[w_rd_addr]) : '0;

  lif_update #(
    .VW            (VW),
    .ACC_W         (ACC_W),
    .THRESHOLD_INC (THRESHOLD_INC),
    .THRESHOLD_DEC (THRESHOLD_DEC),
    .THRESHOLD_MIN (THRESHOLD_MIN),
    .LEAK_SHIFT    (LEAK_SHIFT)
  ) u_update (
    .v_i        (r_v[r_j]),
    .thr_i      (r_thr[r_j]),
    .acc_i      (r_acc),
    .v_next_o   (w_v_next),
    .thr_next_o (w_thr_next),
    .fire_o     (w_fire)
  );

  // State register; reset and clear both abandon any step in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) r_state <= ST_IDLE;
    else                  r_state <= w_state_next;
  end

  // Next-state: N_IN accumulate cycles plus one update cycle per neuron.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_accept) w_state_next = ST_ACCUM;
      ST_ACCUM:  if (r_i == I_LAST) w_state_next = ST_UPDATE;
      ST_UPDATE: w_state_next = (r_j == J_LAST) ? ST_DONE : ST_ACCUM;
      ST_DONE:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Step datapath: latch inputs, walk (j, i), accumulate, collect fire bits.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_i           <= '0;
      r_j           <= '0;
      r_acc         <= '0;
      r_spike_q     <= '0;
      r_spike_q_out <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_spike_q     <= spike_i;
            r_i           <= '0;
            r_j           <= '0;
            r_acc         <= '0;
            r_spike_q_out <= '0;
          end
        end
        ST_ACCUM: begin
          r_acc <= r_acc + w_addend;
          if (r_i != I_LAST) r_i <= r_i + 1'b1;
        end
        ST_UPDATE: begin
          r_spike_q_out[r_j] <= w_fire;
          if (r_j != J_LAST) begin
            r_j   <= r_j + 1'b1;
            r_i   <= '0;
            r_acc <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Output register: publish the step's spikes with a one-cycle valid pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_spike_o     <= '0;
      r_spike_valid <= 1'b0;
    end else begin
      r_spike_valid <= (r_state == ST_DONE);
      if (r_state == ST_DONE) r_spike_o <= r_spike_q_out;
    end
  end

  // Neuron state: membrane and adaptive threshold, written back in UPDATE.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      for (int k = 0; k < N_OUT; k++) begin
        r_v[k]   <= '0;
        r_thr[k] <= VW'(THRESHOLD);
      end
    end else if (r_state == ST_UPDATE) begin
      r_v[r_j]   <= w_v_next;
      r_thr[r_j] <= w_thr_next;
    end
  end

  // Weight RAM: writable in any state; clear keeps it, reset zeroes it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NW; k++) r_w[k] <= '0;
    end else if (w_we_i && ({1'b0, w_addr_i} < NW_L)) begin
      r_w[w_addr_i] <= w_data_i;
    end
  end

endmodule

// File: tb/tb_lif_layer.sv
// Directed bench for lif_layer at default parameters.
module tb_lif_layer;

  localparam int N_IN    = 8;
  localparam int N_OUT   = 10;
  localparam int WIDTH_P = 8;
  localparam int AW      = 7;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               clear = 1'b0;
  logic [N_IN-1:0]    spike_i = '0;
  logic               step_valid = 1'b0;
  logic               step_ready_o;
  logic [N_OUT-1:0]   spike_o;
  logic               spike_valid_o;
  logic               w_we = 1'b0;
  logic [AW-1:0]      w_addr = '0;
  logic [WIDTH_P-1:0] w_data = '0;
  logic [1:0]         dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [N_OUT-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  lif_layer dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .clear_i       (clear),
    .spike_i       (spike_i),
    .step_valid_i  (step_valid),
    .step_ready_o  (step_ready_o),
    .spike_o       (spike_o),
    .spike_valid_o (spike_valid_o),
    .w_we_i        (w_we),
    .w_addr_i      (w_addr),
    .w_data_i      (w_data),
    .dbg_state_o   (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (spike_valid_o) begin
      if (exp_q.size() == 0) check("unexpected_spike_valid", 32'(spike_valid_o), 32'd0);
      else                   check("spike_o", 32'(spike_o), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_w(input int addr, input int data);
    w_we = 1'b1; w_addr = AW'(addr); w_data = WIDTH_P'(data);
    @(negedge clk);
    w_we = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic wait_ready();
    int wt;
    wt = 0;
    while (!step_ready_o && wt < 300) begin @(negedge clk); wt++; end
  endtask

  task automatic run_step(input logic [N_IN-1:0] sp, input logic [N_OUT-1:0] exp,
                          input bit live_wr, input int wr_addr, input int wr_data);
    int lat;
    exp_q.push_back(exp);
    wait_ready();
    check("ready_before_step", 32'(step_ready_o), 32'd1);
    spike_i = sp; step_valid = 1'b1;
    @(negedge clk);
    step_valid = 1'b0; spike_i = '0;
    check("ready_low_after_accept", 32'(step_ready_o), 32'd0);
    lat = 0;
    while (!spike_valid_o && lat < 300) begin
      if (live_wr && lat == 10) begin
        w_we = 1'b1; w_addr = AW'(wr_addr); w_data = WIDTH_P'(wr_data);
      end else begin
        w_we = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    w_we = 1'b0;
    check("latency", 32'(lat), 32'd91);
    check("ready_low_with_valid", 32'(step_ready_o), 32'd0);
    @(negedge clk);
    check("ready_high_after_valid", 32'(step_ready_o), 32'd1);
  endtask

  task automatic abort_step(input logic [N_IN-1:0] sp, input bit use_rst);
    wait_ready();
    spike_i = sp; step_valid = 1'b1;
    @(negedge clk);
    step_valid = 1'b0; spike_i = '0;
    tick(19);
    if (use_rst) rst = 1'b1; else clear = 1'b1;
    @(negedge clk);
    rst = 1'b0; clear = 1'b0;
    check("ready_after_abort", 32'(step_ready_o), 32'd1);
    check("spike_o_after_abort", 32'(spike_o), 32'd0);
    tick(120);
  endtask

  // ---------------- stimulus ----------------
  int acc_cyc [8];
  int n_acc;
  int thr0_seq [5] = '{36, 40, 44, 42, 46};
  int fire0_seq [5] = '{1, 1, 1, 0, 1};
  int v1_seq [6] = '{10, 15, 18, 19, 20, 20};

  initial begin
    tick(3);
    rst = 1'b0;
    @(negedge clk);

    // Reset values
    check("rst_ready", 32'(step_ready_o), 32'd1);
    check("rst_valid", 32'(spike_valid_o), 32'd0);
    check("rst_spike_o", 32'(spike_o), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_thr0", 32'(dut.r_thr[0]), 32'd32);
    check("rst_v9", 32'(dut.r_v[9]), 32'd0);

    // Idle steps: thresholds decay by 2 to the floor of 16
    run_step(8'h00, 10'h000, 1'b0, 0, 0);
    for (int j = 0; j < N_OUT; j++) check("thr_after_1_idle", 32'(dut.r_thr[j]), 32'd30);
    for (int s = 0; s < 7; s++) run_step(8'h00, 10'h000, 1'b0, 0, 0);
    for (int j = 0; j < N_OUT; j++) check("thr_after_8_idle", 32'(dut.r_thr[j]), 32'd16);
    run_step(8'h00, 10'h000, 1'b0, 0, 0);
    check("thr_floor_hold0", 32'(dut.r_thr[0]), 32'd16);
    check("thr_floor_hold9", 32'(dut.r_thr[9]), 32'd16);

    // Held step_valid: one accept every 93 cycles
    for (int k = 0; k < 3; k++) exp_q.push_back(10'h000);
    n_acc = 0;
    for (int k = 0; k < 8; k++) acc_cyc[k] = 0;
    spike_i = 8'h00; step_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (step_ready_o && step_valid && n_acc < 8) begin acc_cyc[n_acc] = c; n_acc++; end
      @(negedge clk);
    end
    step_valid = 1'b0;
    check("accept_count", 32'(n_acc), 32'd3);
    check("accept_gap_1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd93);
    check("accept_gap_2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd93);
    wait_ready();
    tick(2);

    // Fire and adapt on neuron 0
    do_clear();
    write_w(0, 40);
    for (int s = 0; s < 5; s++) begin
      run_step(8'h01, N_OUT'(fire0_seq[s]), 1'b0, 0, 0);
      check("thr0_seq", 32'(dut.r_thr[0]), 32'(thr0_seq[s]));
      if (s == 3) check("v0_after_step4", 32'(dut.r_v[0]), 32'd40);
    end

    // Leak on neuron 1
    do_clear();
    write_w(0, 0);
    write_w(8, 10);
    for (int s = 0; s < 7; s++) begin
      run_step(8'h01, (s == 6) ? 10'h002 : 10'h000, 1'b0, 0, 0);
      if (s < 6) check("v1_seq", 32'(dut.r_v[1]), 32'(v1_seq[s]));
    end

    // Saturation-width accumulation on neuron 2
    do_clear();
    for (int i = 16; i < 24; i++) write_w(i, 255);
    run_step(8'hFF, 10'h004, 1'b0, 0, 0);
    check("thr2_after_sat", 32'(dut.r_thr[2]), 32'd36);
    check("v2_after_fire", 32'(dut.r_v[2]), 32'd0);
    check("v1_after_sat_step", 32'(dut.r_v[1]), 32'd10);

    // Live weight write to neuron 9 before it is read
    do_clear();
    run_step(8'h01, 10'h204, 1'b1, 72, 50);

    // Clear mid-step: no pulse, weights kept
    abort_step(8'h01, 1'b0);
    run_step(8'h01, 10'h204, 1'b0, 0, 0);

    // Reset mid-step: no pulse, weights zeroed
    abort_step(8'h01, 1'b1);
    check("thr9_after_rst", 32'(dut.r_thr[9]), 32'd32);
    run_step(8'hFF, 10'h000, 1'b0, 0, 0);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
